mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port memory arbiter: instruction fetch and data share one memory port.
// Data has priority; fetch is promoted after MAX_CONSEC data grants in a row.
module mem_port_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int MAX_CONSEC = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_e;

  localparam logic [3:0] STARVE_MAX = 4'(MAX_CONSEC);
  localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              if_gnt_q, if_gnt_d;
  logic              if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              d_gnt_q, d_gnt_d;
  logic              d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              err_q, err_d;
  logic              fetch_wins;

  // Fetch only beats a pending data request once it has been starved long enough.
  assign fetch_wins = if_req && (!d_req || (starve_q == STARVE_MAX));

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    tmo_d       = tmo_q;
    if_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_gnt_d     = 1'b0;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = d_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (!if_req) begin
          starve_d = '0;
        end
        if (fetch_wins) begin
          state_d     = BUSY_IF;
          starve_d    = '0;
          tmo_d       = '0;
          if_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
        end else if (d_req) begin
          state_d     = BUSY_D;
          tmo_d       = '0;
          d_gnt_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          if (if_req && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
        end
      end

      BUSY_IF, BUSY_D: begin
        // Requests are ignored here; mem_* stays frozen until the access ends.
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (state_q == BUSY_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end else begin
            d_rvalid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = mem_rdata;
            end
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      tmo_q       <= '0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      d_gnt_q     <= 1'b0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      tmo_q       <= tmo_d;
      if_gnt_q    <= if_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_gnt_q     <= d_gnt_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model,
// plus directed fetch, write, contention, timeout and reset-abort sequences.
module tb_mem_port_arbiter;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int MAX_CONSEC = 4;
  localparam int TIMEOUT    = 64;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset_n;
  logic              if_req, d_req, d_we, mem_ready;
  logic [ADDR_W-1:0] if_addr, d_addr;
  logic [DATA_W-1:0] d_wdata, mem_rdata;
  logic              if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we, err;
  logic [DATA_W-1:0] if_rdata, d_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;

  mem_port_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_CONSEC(MAX_CONSEC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .err(err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endfunction

  // Reference model: one outstanding transaction record plus a data-streak counter.
  bit                m_busy, m_is_d, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  int                m_age, m_streak;
  bit                e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_err, e_mem_req, e_mem_we;
  logic [ADDR_W-1:0] e_mem_addr;
  logic [DATA_W-1:0] e_mem_wdata, e_if_rdata, e_d_rdata;

  function automatic void model_reset();
    m_busy = 0; m_is_d = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_age = 0; m_streak = 0;
    e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0; e_err = 0; e_mem_req = 0; e_mem_we = 0;
    e_mem_addr = '0; e_mem_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
  endfunction

  function automatic void model_edge();
    bit take_if;
    e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0; e_err = 0;
    if (!m_busy) begin
      if (if_req || d_req) begin
        take_if = if_req && (!d_req || m_streak >= MAX_CONSEC);
        m_busy = 1; m_age = 0; m_is_d = !take_if;
        if (take_if) begin
          m_streak = 0; m_we = 0; m_addr = if_addr; m_wdata = '0; e_if_gnt = 1;
        end else begin
          m_streak = if_req ? ((m_streak + 1 > MAX_CONSEC) ? MAX_CONSEC : m_streak + 1) : 0;
          m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; e_d_gnt = 1;
        end
        e_mem_req = 1; e_mem_we = m_we; e_mem_addr = m_addr; e_mem_wdata = m_wdata;
      end else begin
        m_streak = 0;
      end
    end else begin
      m_age++;
      if (mem_ready) begin
        if (m_is_d) begin
          e_d_rv = 1;
          if (!m_we) e_d_rdata = mem_rdata;
        end else begin
          e_if_rv = 1; e_if_rdata = mem_rdata;
        end
        m_busy = 0; e_mem_req = 0; e_mem_we = 0;
      end else if (m_age >= TIMEOUT) begin
        e_err = 1; m_busy = 0; e_mem_req = 0; e_mem_we = 0;
      end
    end
  endfunction

  bit         log_en = 0;
  int         log_n  = 0;
  logic [9:0] log_bits = '0;

  task automatic compare_all();
    check("if_gnt", if_gnt, e_if_gnt);
    check("d_gnt", d_gnt, e_d_gnt);
    check("if_rvalid", if_rvalid, e_if_rv);
    check("d_rvalid", d_rvalid, e_d_rv);
    check("err", err, e_err);
    check("mem_req", mem_req, e_mem_req);
    check("if_rdata", if_rdata, e_if_rdata);
    check("d_rdata", d_rdata, e_d_rdata);
    if (e_mem_req) begin
      check("mem_we", mem_we, e_mem_we);
      check("mem_addr", mem_addr, e_mem_addr);
      check("mem_wdata", mem_wdata, e_mem_wdata);
    end
    if (log_en) begin
      if (d_gnt)  begin log_bits = {log_bits[8:0], 1'b1}; log_n++; end
      if (if_gnt) begin log_bits = {log_bits[8:0], 1'b0}; log_n++; end
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    if (reset_n) model_edge();
    #1;
    compare_all();
  endtask

  int n;
  bit seen_rv;
  bit if_pend, d_pend;
  int stall_left;

  initial begin
    reset_n = 1'b0;
    if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 compare_all();
    @(negedge clock) reset_n = 1'b1;
    cycle();

    // Single fetch with memory ready in the grant cycle.
    if_req = 1; if_addr = 32'h40; mem_ready = 1; mem_rdata = 32'h1234_5678;
    cycle();
    check("fetch_gnt", if_gnt, 1);
    check("fetch_mem_req", mem_req, 1);
    check("fetch_mem_addr", mem_addr, 32'h40);
    if_req = 0;
    cycle();
    check("fetch_rvalid", if_rvalid, 1);
    check("fetch_rdata", if_rdata, 32'h1234_5678);
    cycle();

    // Read to seed d_rdata, then a write that must leave it untouched.
    d_req = 1; d_we = 0; d_addr = 32'h200; mem_rdata = 32'hA5A5_0001;
    cycle(); d_req = 0; cycle(); cycle();
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; mem_ready = 0;
    cycle();
    check("wr_gnt", d_gnt, 1);
    check("wr_mem_we", mem_we, 1);
    check("wr_mem_addr", mem_addr, 32'h100);
    check("wr_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    d_req = 0; d_addr = 32'h3FC; d_wdata = 32'h0; d_we = 0;
    cycle();
    check("stable_addr", mem_addr, 32'h100);
    check("stable_we", mem_we, 1);
    mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
    cycle();
    check("wr_rvalid", d_rvalid, 1);
    check("wr_rdata_kept", d_rdata, 32'hA5A5_0001);
    mem_ready = 0;
    cycle();

    // Both ports hammering with memory always ready.
    log_en = 1; log_n = 0; log_bits = '0;
    d_req = 1; d_we = 0; d_addr = 32'h80; if_req = 1; if_addr = 32'h1000; mem_ready = 1;
    for (int c = 0; c < 200 && log_n < 10; c++) begin
      mem_rdata = $urandom;
      cycle();
    end
    log_en = 0; d_req = 0; if_req = 0;
    check("contention_count", log_n, 10);
    check("contention_order", log_bits, 10'b1111011110);
    cycle(); cycle();

    // Memory never answers: abort after TIMEOUT busy cycles.
    d_req = 1; d_we = 0; d_addr = 32'h84; mem_ready = 0;
    cycle();
    check("tmo_gnt", d_gnt, 1);
    d_req = 0; n = 1; seen_rv = 0;
    while (!err && n < 200) begin
      cycle(); n++;
      if (d_rvalid) seen_rv = 1;
    end
    check("tmo_busy_cycles", n - 1, TIMEOUT);
    check("tmo_mem_req_drop", mem_req, 0);
    check("tmo_no_rvalid", seen_rv, 0);
    cycle();

    // Memory answers exactly on the last allowed busy cycle.
    d_req = 1; d_addr = 32'h88;
    cycle();
    d_req = 0; n = 1;
    while (n < TIMEOUT) begin cycle(); n++; end
    mem_ready = 1; mem_rdata = 32'h0BAD_F00D;
    cycle();
    check("late_rvalid", d_rvalid, 1);
    check("late_no_err", err, 0);
    check("late_rdata", d_rdata, 32'h0BAD_F00D);
    mem_ready = 0;
    cycle();

    // Asynchronous reset while a data read is outstanding.
    d_req = 1; d_addr = 32'h44;
    cycle(); d_req = 0; cycle(); cycle();
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_d_rvalid", d_rvalid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_d_rdata", d_rdata, 0);
    mem_ready = 1;
    @(posedge clock); #1 compare_all();
    @(negedge clock) reset_n = 1'b1;
    mem_ready = 0; if_req = 1; if_addr = 32'h500;
    cycle();
    check("post_rst_if_gnt", if_gnt, 1);
    check("post_rst_mem_addr", mem_addr, 32'h500);
    if_req = 0; mem_ready = 1; mem_rdata = 32'h5555_AAAA;
    cycle();
    check("post_rst_if_rvalid", if_rvalid, 1);
    mem_ready = 0;
    cycle();

    // Random traffic with occasional long memory stalls.
    if_pend = 0; d_pend = 0; stall_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (if_gnt) if_pend = 0;
      if (d_gnt)  d_pend = 0;
      if (!if_pend && $urandom_range(0, 99) < 35) begin
        if_pend = 1; if_addr = $urandom;
      end
      if (!d_pend) begin
        d_addr = $urandom; d_wdata = $urandom; d_we = $urandom_range(0, 1);
        if ($urandom_range(0, 99) < 40) d_pend = 1;
      end
      if_req = if_pend; d_req = d_pend;
      if (stall_left > 0) begin
        mem_ready = 0; stall_left--;
      end else if ($urandom_range(0, 199) == 0) begin
        stall_left = $urandom_range(50, 90); mem_ready = 0;
      end else begin
        mem_ready = ($urandom_range(0, 99) < 45);
      end
      mem_rdata = $urandom;
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
